cpu_run_ctrl: RTL and testbench

Synthesizable run-control sequencer between the board/top level and one or more CPU cores. It stretches the per-core reset for a programmable number of cycles, then gates core execution in free-run or single-step mode. It counts executed cycles and stops the cores on a cycle limit, a core halt request, or an external abort. It replaces the fixed-delay reset/run stimulus of the simulation bench with hardware usable on the FPGA.

---
 rtl/cpu_run_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run-control sequencer for one or more CPU cores. Holds the cores
//            in reset for RST_CYCLES after start, then enables them in
//            free-run or single-step mode. Counts executed cycles and stops
//            on abort, a core halt request or a cycle limit.
// Ports    : clk, rst        - clock (rising edge), async active-high reset
//            start, abort    - begin a run / stop a running run
//            step_mode       - 0 free-run, 1 single-step (latched at start)
//            step_req        - grants one execution cycle per high cycle
//            run_limit       - executed-cycle limit, 0 = unlimited
//            core_mask       - cores taking part in the run
//            halt_in         - per-core halt request
//            core_rst        - per-core reset, active-high
//            core_en         - per-core clock enable
//            cycle_cnt       - executed cycles in current/last run
//            busy, done      - run in progress / run finished
//            halt_cause      - 00 none, 01 core halt, 10 limit, 11 abort
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int NUM_CORES  = 1,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic [CNT_W-1:0]     run_limit,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] halt_in,
    output logic [NUM_CORES-1:0] core_rst,
    output logic [NUM_CORES-1:0] core_en,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           halt_cause
);

    localparam int c_rcnt_w = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_rcnt_w-1:0] c_rcnt_load = c_rcnt_w'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max   = '1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_reset = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_step  = 3'd3;
    localparam logic [2:0] c_st_halt  = 3'd4;

    localparam logic [1:0] c_cause_none  = 2'b00;
    localparam logic [1:0] c_cause_halt  = 2'b01;
    localparam logic [1:0] c_cause_limit = 2'b10;
    localparam logic [1:0] c_cause_abort = 2'b11;

    logic                 r_rst_hold;
    logic [2:0]           r_state;
    logic [NUM_CORES-1:0] r_mask;
    logic [CNT_W-1:0]     r_limit;
    logic                 r_mode;
    logic [c_rcnt_w-1:0]  r_rcnt;

    logic [2:0]           w_state;
    logic [NUM_CORES-1:0] w_mask;
    logic [CNT_W-1:0]     w_limit;
    logic                 w_mode;
    logic [c_rcnt_w-1:0]  w_rcnt;
    logic [CNT_W-1:0]     w_cnt;
    logic [1:0]           w_cause;
    logic [NUM_CORES-1:0] w_core_rst;
    logic [NUM_CORES-1:0] w_core_en;
    logic                 w_busy;
    logic                 w_done;

    logic                 w_cnt_inc;
    logic [CNT_W-1:0]     w_cnt_plus;
    logic                 w_limit_hit;
    logic                 w_halt_hit;

    // Reset release is synchronised: the flop stays set for the first edge
    // after rst falls, so the controller first acts on the second edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
        end
    end

    // An enabled cycle ends at this edge; the counter sticks at all ones.
    assign w_cnt_inc   = (|core_en) && (cycle_cnt != c_cnt_max);
    assign w_cnt_plus  = cycle_cnt + CNT_W'(1);
    assign w_limit_hit = w_cnt_inc && (r_limit != '0) && (w_cnt_plus == r_limit);
    assign w_halt_hit  = |(halt_in & r_mask);

    always_comb begin
        w_state = r_state;
        w_mask  = r_mask;
        w_limit = r_limit;
        w_mode  = r_mode;
        w_rcnt  = r_rcnt;
        w_cnt   = w_cnt_inc ? w_cnt_plus : cycle_cnt;
        w_cause = halt_cause;

        case (r_state)
            c_st_idle, c_st_halt: begin
                if (start) begin
                    w_mask  = core_mask;
                    w_limit = run_limit;
                    w_mode  = step_mode;
                    w_cnt   = '0;
                    w_cause = c_cause_none;
                    w_rcnt  = c_rcnt_load;
                    w_state = c_st_reset;
                end
            end
            c_st_reset: begin
                if (r_rcnt == '0) begin
                    w_state = r_mode ? c_st_step : c_st_run;
                end else begin
                    w_rcnt = r_rcnt - 1'b1;
                end
            end
            c_st_run, c_st_step: begin
                if (abort) begin
                    w_state = c_st_halt;
                    w_cause = c_cause_abort;
                end else if (w_halt_hit) begin
                    w_state = c_st_halt;
                    w_cause = c_cause_halt;
                end else if (w_limit_hit) begin
                    w_state = c_st_halt;
                    w_cause = c_cause_limit;
                end
            end
            default: begin
                w_state = c_st_idle;
            end
        endcase

        // While the reset release is pending everything is forced back to
        // its reset value.
        if (r_rst_hold) begin
            w_state = c_st_idle;
            w_mask  = '0;
            w_limit = '0;
            w_mode  = 1'b0;
            w_rcnt  = '0;
            w_cnt   = '0;
            w_cause = c_cause_none;
        end

        // Outputs are registered, so they are derived from the next state.
        // Masked-off cores stay in reset for the whole run and in HALT.
        w_core_rst = '1;
        if ((w_state == c_st_run) || (w_state == c_st_step) || (w_state == c_st_halt)) begin
            w_core_rst = ~w_mask;
        end

        // In STEP a request seen at this edge enables the following cycle;
        // requests are only honoured once STEP has actually been entered.
        w_core_en = '0;
        if (w_state == c_st_run) begin
            w_core_en = w_mask;
        end else if ((w_state == c_st_step) && (r_state == c_st_step) && step_req) begin
            w_core_en = w_mask;
        end

        w_busy = (w_state == c_st_reset) || (w_state == c_st_run) || (w_state == c_st_step);
        w_done = (w_state == c_st_halt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_mask     <= '0;
            r_limit    <= '0;
            r_mode     <= 1'b0;
            r_rcnt     <= '0;
            cycle_cnt  <= '0;
            halt_cause <= c_cause_none;
            core_rst   <= '1;
            core_en    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_mask     <= w_mask;
            r_limit    <= w_limit;
            r_mode     <= w_mode;
            r_rcnt     <= w_rcnt;
            cycle_cnt  <= w_cnt;
            halt_cause <= w_cause;
            core_rst   <= w_core_rst;
            core_en    <= w_core_en;
            busy       <= w_busy;
            done       <= w_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Self-checking bench for cpu_run_ctrl (2 cores, 4-bit counter).
//            Table of directed runs, hand sequences for reset/halt corner
//            cases, and randomized runs checked against a run-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int NC   = 2;
    localparam int CW   = 4;
    localparam int RSTC = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          step_mode;
    logic          step_req;
    logic [CW-1:0] run_limit;
    logic [NC-1:0] core_mask;
    logic [NC-1:0] halt_in;
    logic [NC-1:0] core_rst;
    logic [NC-1:0] core_en;
    logic [CW-1:0] cycle_cnt;
    logic          busy;
    logic          done;
    logic [1:0]    halt_cause;

    cpu_run_ctrl #(
        .NUM_CORES  (NC),
        .CNT_W      (CW),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .run_limit  (run_limit),
        .core_mask  (core_mask),
        .halt_in    (halt_in),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .cycle_cnt  (cycle_cnt),
        .busy       (busy),
        .done       (done),
        .halt_cause (halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run stimulus schedule, indexed by edge number after entering
    // RUN/STEP (edge 0 is the entry edge itself).
    bit            abort_s [64];
    logic [NC-1:0] halt_s  [64];
    bit            step_s  [64];
    // Model predictions.
    bit            exp_en  [64];
    int            exp_cnt [64];
    int            m_kend;
    int            m_cause;

    typedef struct {
        logic [NC-1:0] mask;
        logic [CW-1:0] limit;
        bit            mode;
        int            halt_k;
        logic [NC-1:0] halt_v;
        int            abort_k;
        logic [15:0]   steps;
        int            exp_cnt;
        int            exp_cause;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int k = 0; k < 64; k++) begin
            abort_s[k] = 1'b0;
            halt_s[k]  = '0;
            step_s[k]  = 1'b0;
        end
    endtask

    task automatic fill_sched(input int halt_k, input logic [NC-1:0] halt_v,
                              input int abort_k, input logic [15:0] steps);
        clear_sched();
        for (int k = 1; k < 16; k++) step_s[k] = steps[k];
        if (halt_k > 0) halt_s[halt_k] = halt_v;
        abort_s[abort_k] = 1'b1;
    endtask

    // Run-level model: walks enabled cycles, counts them (saturating) and
    // finds the first edge where abort, an unmasked halt, or reaching the
    // limit ends the run.
    task automatic predict(input logic [NC-1:0] mask, input int limit, input bit mode, input int n);
        int cnt;
        bit en_prev;
        bit hit;
        cnt     = 0;
        en_prev = !mode;
        m_kend  = n;
        m_cause = 0;
        for (int k = 1; k <= n; k++) begin
            hit = 1'b0;
            if (en_prev && (mask != 0) && (cnt < MAXC)) begin
                cnt = cnt + 1;
                hit = (limit != 0) && (cnt == limit);
            end
            exp_cnt[k] = cnt;
            if (abort_s[k])                  m_cause = 3;
            else if ((halt_s[k] & mask) != 0) m_cause = 1;
            else if (hit)                    m_cause = 2;
            if (m_cause != 0) begin
                m_kend    = k;
                exp_en[k] = 1'b0;
                break;
            end
            en_prev   = mode ? step_s[k] : 1'b1;
            exp_en[k] = en_prev;
        end
    endtask

    // Starts a run from IDLE/HALT, follows it to its end and checks every
    // cycle against the model. Inputs that must be ignored are randomized.
    task automatic run_sched(input logic [NC-1:0] mask, input logic [CW-1:0] limit,
                             input bit mode, input int n,
                             output int got_cnt, output int got_cause);
        logic [NC-1:0] nmask;
        logic [NC-1:0] all1;
        nmask = ~mask;
        all1  = '1;
        predict(mask, int'(limit), mode, n);
        core_mask = mask;
        run_limit = limit;
        step_mode = mode;
        halt_in   = '0;
        abort     = 1'b0;
        step_req  = 1'b0;
        start     = 1'b1;
        tick();
        chk("start_busy",  busy, 1);
        chk("start_rst",   core_rst, all1);
        chk("start_en",    core_en, 0);
        chk("start_cnt",   cycle_cnt, 0);
        chk("start_done",  done, 0);
        chk("start_cause", halt_cause, 0);
        for (int i = 0; i < RSTC; i++) begin
            start    = 1'($urandom_range(0, 1));
            abort    = 1'($urandom_range(0, 1));
            halt_in  = NC'($urandom);
            step_req = 1'($urandom_range(0, 1));
            tick();
            if (i < RSTC - 1) begin
                chk("rsthold_rst",  core_rst, all1);
                chk("rsthold_en",   core_en, 0);
                chk("rsthold_busy", busy, 1);
            end
        end
        chk("entry_rst", core_rst, nmask);
        chk("entry_en",  core_en, mode ? 0 : mask);
        chk("entry_cnt", cycle_cnt, 0);
        for (int k = 1; k <= m_kend; k++) begin
            halt_in  = halt_s[k];
            abort    = abort_s[k];
            step_req = step_s[k];
            start    = 1'($urandom_range(0, 1));
            tick();
            if (k < m_kend) begin
                chk("run_en",   core_en, exp_en[k] ? mask : '0);
                chk("run_cnt",  cycle_cnt, exp_cnt[k]);
                chk("run_busy", busy, 1);
            end
        end
        start    = 1'b0;
        halt_in  = '0;
        abort    = 1'b0;
        step_req = 1'b0;
        chk("end_done",  done, 1);
        chk("end_busy",  busy, 0);
        chk("end_en",    core_en, 0);
        chk("end_rst",   core_rst, nmask);
        chk("end_cnt",   cycle_cnt, exp_cnt[m_kend]);
        chk("end_cause", halt_cause, m_cause);
        got_cnt   = int'(cycle_cnt);
        got_cause = int'(halt_cause);
    endtask

    initial begin
        int gc;
        int gca;
        int n;

        //           mask   lim mode hk hv     ak  steps     cnt cause
        tbl[0]  = '{2'b01, 10, 0,   0, 2'b00, 40, 16'h0000, 10, 2};
        tbl[1]  = '{2'b01,  0, 0,   7, 2'b01, 30, 16'h0000,  7, 1};
        tbl[2]  = '{2'b01,  0, 0,   3, 2'b10,  6, 16'h0000,  6, 3};
        tbl[3]  = '{2'b01,  0, 0,   5, 2'b01,  5, 16'h0000,  5, 3};
        tbl[4]  = '{2'b01,  5, 0,   5, 2'b01, 20, 16'h0000,  5, 1};
        tbl[5]  = '{2'b00,  3, 0,   2, 2'b11,  9, 16'h0000,  0, 3};
        tbl[6]  = '{2'b11,  1, 0,   0, 2'b00, 10, 16'h0000,  1, 2};
        tbl[7]  = '{2'b01,  0, 1,   0, 2'b00, 15, 16'h0F54,  7, 3};
        tbl[8]  = '{2'b01,  0, 0,   0, 2'b00, 20, 16'h0000, 15, 3};
        tbl[9]  = '{2'b10,  4, 1,   0, 2'b00, 30, 16'hFFFE,  4, 2};
        tbl[10] = '{2'b01,  7, 1,   0, 2'b00, 20, 16'h0F54,  7, 2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        run_limit = '0; core_mask = '0; halt_in = '0;
        #3;
        chk("rst_core_rst", core_rst, 2'b11);
        chk("rst_core_en",  core_en, 0);
        chk("rst_cnt",      cycle_cnt, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_done",     done, 0);
        chk("rst_cause",    halt_cause, 0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            fill_sched(tbl[i].halt_k, tbl[i].halt_v, tbl[i].abort_k, tbl[i].steps);
            run_sched(tbl[i].mask, tbl[i].limit, tbl[i].mode, tbl[i].abort_k, gc, gca);
            chk($sformatf("tbl%0d_cnt", i),   gc,  tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_cause", i), gca, tbl[i].exp_cause);
        end

        // Core halt, then halt_in/abort/step_req in HALT change nothing.
        fill_sched(7, 2'b01, 30, 16'h0000);
        run_sched(2'b01, 0, 1'b0, 30, gc, gca);
        halt_in = 2'b11; abort = 1'b1; step_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_done",  done, 1);
            chk("hold_cnt",   cycle_cnt, 7);
            chk("hold_cause", halt_cause, 1);
            chk("hold_en",    core_en, 0);
            chk("hold_rst",   core_rst, 2'b10);
        end
        halt_in = '0; abort = 1'b0; step_req = 1'b0;

        // Reset in the middle of a run, then restart after release.
        core_mask = 2'b11; run_limit = '0; step_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RSTC) tick();
        chk("mid_entry_en", core_en, 2'b11);
        repeat (5) tick();
        chk("mid_cnt_pre", cycle_cnt, 5);
        #2 rst = 1'b1;
        #1;
        chk("mid_core_rst", core_rst, 2'b11);
        chk("mid_core_en",  core_en, 0);
        chk("mid_cnt",      cycle_cnt, 0);
        chk("mid_busy",     busy, 0);
        chk("mid_done",     done, 0);
        chk("mid_cause",    halt_cause, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; core_mask = 2'b01; run_limit = 3;
        tick();
        chk("rel_edge1_busy", busy, 0);
        tick();
        chk("rel_edge2_busy", busy, 1);
        start = 1'b0;
        repeat (RSTC) tick();
        chk("rel_run_en",  core_en, 2'b01);
        chk("rel_run_rst", core_rst, 2'b10);
        repeat (3) tick();
        chk("rel_done",  done, 1);
        chk("rel_cnt",   cycle_cnt, 3);
        chk("rel_cause", halt_cause, 2);

        // Randomized runs against the model.
        for (int r = 0; r < 40; r++) begin
            clear_sched();
            n = $urandom_range(3, 30);
            for (int k = 1; k <= n; k++) begin
                abort_s[k] = ($urandom_range(0, 40) == 0);
                halt_s[k]  = ($urandom_range(0, 12) == 0) ? NC'($urandom) : '0;
                step_s[k]  = 1'($urandom_range(0, 1));
            end
            abort_s[n] = 1'b1;
            run_sched(NC'($urandom), CW'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), n, gc, gca);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
